// File: rtl/sha_block_feeder.sv
// Word-stream to 16-word block assembler feeding stage 0 of the SHA-256 pipeline.
// Presents each completed block as a W window with valid/newblock qualifiers.
module sha_block_feeder (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      word_i,
  input  logic             word_valid_i,
  input  logic             word_last_i,
  output logic [15:0][31:0] W_o,
  output logic             valid_o,
  output logic             newblock_o,
  output logic             err_o,
  output logic [31:0]      blocks_o
);

  typedef enum logic {StStart, StCont} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [3:0]       r_idx;
  logic [3:0]       w_idx_d;
  logic [14:0][31:0] r_buf;
  logic [15:0][31:0] r_w;
  logic             r_valid;
  logic             r_newblock;
  logic             r_err;
  logic [31:0]      r_blocks;

  logic             w_emit;
  logic             w_frame_err;
  logic             w_buf_we;

  assign w_emit      = word_valid_i && (r_idx == 4'd15);
  assign w_frame_err = word_valid_i && word_last_i && (r_idx != 4'd15);
  // The 16th word bypasses the buffer straight into the output register.
  assign w_buf_we    = word_valid_i && (r_idx != 4'd15);

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    if (w_frame_err) begin
      w_state_d = StStart;
      w_idx_d   = 4'd0;
    end else if (w_emit) begin
      w_state_d = word_last_i ? StStart : StCont;
      w_idx_d   = 4'd0;
    end else if (word_valid_i) begin
      w_idx_d   = r_idx + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StStart;
      r_idx      <= 4'd0;
      r_w        <= '0;
      r_valid    <= 1'b0;
      r_newblock <= 1'b0;
      r_err      <= 1'b0;
      r_blocks   <= 32'd0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_valid <= w_emit;
      if (w_emit) begin
        r_w        <= {word_i, r_buf};
        r_newblock <= (r_state == StStart);
        r_blocks   <= r_blocks + 32'd1;
      end
      if (w_frame_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (!rst && w_buf_we) begin
      r_buf[r_idx] <= word_i;
    end
  end

  assign W_o        = r_w;
  assign valid_o    = r_valid;
  assign newblock_o = r_newblock;
  assign err_o      = r_err;
  assign blocks_o   = r_blocks;

endmodule

// File: tb/tb_sha_block_feeder.sv
// Scoreboard bench for sha_block_feeder: driver pushes expected blocks, a monitor
// pops and compares on every valid_o pulse.
module tb_sha_block_feeder;

  logic              clk;
  logic              rst;
  logic [31:0]       word_i;
  logic              word_valid_i;
  logic              word_last_i;
  logic [15:0][31:0] W_o;
  logic              valid_o;
  logic              newblock_o;
  logic              err_o;
  logic [31:0]       blocks_o;

  sha_block_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_last_i  (word_last_i),
    .W_o          (W_o),
    .valid_o      (valid_o),
    .newblock_o   (newblock_o),
    .err_o        (err_o),
    .blocks_o     (blocks_o)
  );

  typedef struct {
    logic [15:0][31:0] w;
    logic              nb;
    logic [31:0]       blk;
    int                cyc;
  } exp_t;

  exp_t              q[$];
  int                tests = 0;
  int                fails = 0;
  int                cyc   = 0;
  logic [31:0]       exp_blocks = 32'd0;
  logic              exp_first  = 1'b1;
  logic [15:0][31:0] last_w = '0;
  bit                stab_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (valid_o === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 512'(valid_o), 512'd0);
      end else begin
        e = q.pop_front();
        chk("W_o", 512'(W_o), 512'(e.w));
        chk("newblock_o", 512'(newblock_o), 512'(e.nb));
        chk("blocks_o", 512'(blocks_o), 512'(e.blk));
        chk("pulse_cycle", 512'(cyc), 512'(e.cyc));
        last_w = e.w;
      end
    end else if (stab_en) begin
      chk("W_hold", 512'(W_o), 512'(last_w));
    end
  end

  task automatic drive_word(input logic [31:0] w, input logic last);
    word_i       = w;
    word_valid_i = 1'b1;
    word_last_i  = last;
    @(negedge clk);
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
  endtask

  task automatic send_block(input logic [15:0][31:0] blk, input logic last, input bit gap);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        e.w   = blk;
        e.nb  = exp_first;
        e.blk = exp_blocks + 32'd1;
        e.cyc = cyc + 1;
        q.push_back(e);
        exp_blocks = exp_blocks + 32'd1;
        exp_first  = last;
      end
      drive_word(blk[i], last && (i == 15));
      if (gap) begin
        // Idle cycle with a stray last flag, which must be ignored.
        word_i      = 32'hDEAD_0000 | 32'(i);
        word_last_i = 1'b1;
        @(negedge clk);
        word_last_i = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 512'(q.size()), 512'd0);
  endtask

  logic [15:0][31:0] blk_cnt;
  logic [15:0][31:0] blk_hdr0;
  logic [15:0][31:0] blk_hdr1;
  logic [15:0][31:0] blk_alt;

  initial begin
    for (int k = 0; k < 16; k++) begin
      blk_cnt[k]  = 32'(k);
      blk_hdr0[k] = 32'hB1C0_0000 + 32'(k);
      blk_alt[k]  = 32'hA5A5_0000 ^ (32'(k) << 8);
    end
    // Second half of an 80-byte header followed by SHA-256 padding (length 640 bits).
    for (int k = 0; k < 16; k++) blk_hdr1[k] = 32'd0;
    for (int k = 0; k < 4; k++) blk_hdr1[k] = 32'hB1C0_0010 + 32'(k);
    blk_hdr1[4]  = 32'h8000_0000;
    blk_hdr1[15] = 32'h0000_0280;

    rst = 1'b1; word_i = '0; word_valid_i = 1'b0; word_last_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_W_o", 512'(W_o), 512'd0);
    chk("rst_valid_o", 512'(valid_o), 512'd0);
    chk("rst_newblock_o", 512'(newblock_o), 512'd0);
    chk("rst_err_o", 512'(err_o), 512'd0);
    chk("rst_blocks_o", 512'(blocks_o), 512'd0);
    last_w  = '0;
    stab_en = 1'b1;

    // Single-block message.
    send_block(blk_cnt, 1'b1, 1'b0);
    drain();
    chk("single_blocks_o", 512'(blocks_o), 512'd1);

    // Two-block message then a fresh single-block message.
    send_block(blk_hdr0, 1'b0, 1'b0);
    send_block(blk_hdr1, 1'b1, 1'b0);
    send_block(blk_alt, 1'b1, 1'b0);
    drain();

    // Gapped input reproduces the gapless block.
    send_block(blk_cnt, 1'b1, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    // Framing error on the 5th word.
    for (int k = 0; k < 4; k++) drive_word(32'h0BAD_0000 + 32'(k), 1'b0);
    chk("err_before", 512'(err_o), 512'd0);
    drive_word(32'h0BAD_0004, 1'b1);
    chk("err_set", 512'(err_o), 512'd1);
    exp_first = 1'b1;
    send_block(blk_alt, 1'b1, 1'b0);
    drain();
    chk("err_sticky", 512'(err_o), 512'd1);

    // Reset mid-block, simultaneous with a valid word.
    for (int k = 0; k < 9; k++) drive_word(32'h0DD0_0000 + 32'(k), 1'b0);
    stab_en      = 1'b0;
    rst          = 1'b1;
    word_i       = 32'h0DD0_0009;
    word_valid_i = 1'b1;
    @(negedge clk);
    rst = 1'b0; word_valid_i = 1'b0;
    chk("mrst_W_o", 512'(W_o), 512'd0);
    chk("mrst_valid_o", 512'(valid_o), 512'd0);
    chk("mrst_newblock_o", 512'(newblock_o), 512'd0);
    chk("mrst_err_o", 512'(err_o), 512'd0);
    chk("mrst_blocks_o", 512'(blocks_o), 512'd0);
    last_w     = '0;
    stab_en    = 1'b1;
    exp_blocks = 32'd0;
    exp_first  = 1'b1;
    send_block(blk_hdr0, 1'b1, 1'b0);
    drain();

    // Counter wrap via backdoor preload.
    force dut.r_blocks = 32'hFFFF_FFFF;
    #1;
    release dut.r_blocks;
    exp_blocks = 32'hFFFF_FFFF;
    @(negedge clk);
    send_block(blk_cnt, 1'b1, 1'b0);
    drain();
    chk("wrap_blocks_o", 512'(blocks_o), 512'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
